// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the 32-bit bus datapath.
// The sequencer is the master: it consumes run/ir and drives every strobe.
interface control_sequencer_if;
    logic        run;
    logic [31:0] ir;

    logic        PCout;
    logic        PC_in;
    logic        Inc_PC;
    logic        MAR_in;
    logic        read;
    logic        MDR_in;
    logic        MDRout;
    logic        IR_in;
    logic        Y_in;
    logic        Z_in;
    logic        ZLOWout;
    logic        ZHIout;
    logic        HI_in;
    logic        LO_in;

    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [3:0]  ALU_select;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  run, ir,
        output PCout, PC_in, Inc_PC, MAR_in, read, MDR_in, MDRout, IR_in,
               Y_in, Z_in, ZLOWout, ZHIout, HI_in, LO_in,
               r_in, r_out, ALU_select, halted, state
    );

    modport slave (
        output run, ir,
        input  PCout, PC_in, Inc_PC, MAR_in, read, MDR_in, MDRout, IR_in,
               Y_in, Z_in, ZLOWout, ZHIout, HI_in, LO_in,
               r_in, r_out, ALU_select, halted, state
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and register-register ALU execute
// (T3-T6). Outputs are a pure function of the state register and the IR.
module control_sequencer #(
    parameter logic [4:0] NOP_OP  = 5'b11010,
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  logic                  clk,
    input  logic                  clr,
    control_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OPK_NONE,
        OPK_BINARY,
        OPK_UNARY,
        OPK_MULDIV
    } op_kind_t;

    typedef struct packed {
        op_kind_t   kind;
        logic [3:0] alu_sel;
    } op_decode_t;

    function automatic op_decode_t decode_op(input logic [4:0] opcode);
        op_decode_t d;
        d.kind    = OPK_NONE;
        d.alu_sel = 4'b0000;
        case (opcode)
            5'b00011: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0001; end // add
            5'b00100: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0010; end // sub
            5'b00101: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0101; end // shr
            5'b00110: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0110; end // shl
            5'b00111: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0111; end // ror
            5'b01000: begin d.kind = OPK_BINARY; d.alu_sel = 4'b1000; end // rol
            5'b01001: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0011; end // and
            5'b01010: begin d.kind = OPK_BINARY; d.alu_sel = 4'b0100; end // or
            5'b01111: begin d.kind = OPK_MULDIV; d.alu_sel = 4'b1001; end // mul
            5'b10000: begin d.kind = OPK_MULDIV; d.alu_sel = 4'b1010; end // div
            5'b10001: begin d.kind = OPK_UNARY;  d.alu_sel = 4'b1011; end // neg
            5'b10010: begin d.kind = OPK_UNARY;  d.alu_sel = 4'b1100; end // not
            default:  ;
        endcase
        return d;
    endfunction

    state_t     state_q;
    state_t     state_d;
    state_t     end_state;
    op_decode_t op;
    logic [4:0] opcode;
    logic [15:0] ra_hot;
    logic [15:0] rb_hot;
    logic [15:0] rc_hot;
    logic       is_halt;
    logic       is_skip;

    assign opcode  = bus.ir[31:27];
    assign op      = decode_op(opcode);
    assign ra_hot  = 16'd1 << bus.ir[26:23];
    assign rb_hot  = 16'd1 << bus.ir[22:19];
    assign rc_hot  = 16'd1 << bus.ir[18:15];
    assign is_halt = (opcode == HALT_OP);
    // NOP_OP is checked explicitly so it stays a no-op even if retargeted onto an ALU opcode.
    assign is_skip = (opcode == NOP_OP) || (op.kind == OPK_NONE);

    // run is only looked at when an instruction finishes or while idle.
    assign end_state = bus.run ? S_T0 : S_IDLE;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        bus.PCout      = 1'b0;
        bus.PC_in      = 1'b0;
        bus.Inc_PC     = 1'b0;
        bus.MAR_in     = 1'b0;
        bus.read       = 1'b0;
        bus.MDR_in     = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IR_in      = 1'b0;
        bus.Y_in       = 1'b0;
        bus.Z_in       = 1'b0;
        bus.ZLOWout    = 1'b0;
        bus.ZHIout     = 1'b0;
        bus.HI_in      = 1'b0;
        bus.LO_in      = 1'b0;
        bus.r_in       = 16'h0000;
        bus.r_out      = 16'h0000;
        bus.ALU_select = 4'b0000;
        bus.halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_T0;
            end
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MAR_in = 1'b1;
                bus.Inc_PC = 1'b1;
                bus.Z_in   = 1'b1;
                state_d    = S_T1;
            end
            S_T1: begin
                bus.ZLOWout = 1'b1;
                bus.PC_in   = 1'b1;
                bus.read    = 1'b1;
                bus.MDR_in  = 1'b1;
                state_d     = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IR_in  = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_skip) begin
                    state_d = end_state;
                end else begin
                    bus.r_out = rb_hot;
                    bus.Y_in  = 1'b1;
                    state_d   = S_T4;
                end
            end
            S_T4: begin
                // Unary ops have only Rb; it goes to the ALU's B input as well.
                bus.r_out      = (op.kind == OPK_UNARY) ? rb_hot : rc_hot;
                bus.ALU_select = op.alu_sel;
                bus.Z_in       = 1'b1;
                state_d        = S_T5;
            end
            S_T5: begin
                bus.ZLOWout = 1'b1;
                if (op.kind == OPK_MULDIV) begin
                    bus.LO_in = 1'b1;
                    state_d   = S_T6;
                end else begin
                    bus.r_in  = ra_hot;
                    state_d   = end_state;
                end
            end
            S_T6: begin
                bus.ZHIout = 1'b1;
                bus.HI_in  = 1'b1;
                state_d    = end_state;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule
